// File: rtl/msrv32_instr_fetch_ctrl_if.sv
// Instruction-memory fetch bus between the fetch controller (master) and
// instruction memory (slave): one outstanding word request, completed by ack.
interface msrv32_instr_fetch_ctrl_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;

    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_ack_in, imem_rdata_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_ack_in, imem_rdata_in
    );
endinterface

// File: rtl/msrv32_instr_fetch_ctrl.sv
// MS-RISC32 instruction fetch controller: one word fetch at a time from the
// current PC, results buffered with their PCs in a small queue for decode.
module msrv32_instr_fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic                              ms_risc32_mp_clk_in,
    input  logic                              ms_risc32_mp_rst_in,
    input  logic [31:0]                       pc_in,
    input  logic                              fetch_en_in,
    input  logic                              flush_in,
    msrv32_instr_fetch_ctrl_if.master         imem,
    output logic                              pc_advance_out,
    output logic                              instr_valid_out,
    output logic [31:0]                       instr_out,
    output logic [31:0]                       instr_pc_out,
    input  logic                              instr_ready_in,
    output logic                              misaligned_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t             state, nstate;
    logic               start, mis_set, outstanding, space, push, pop;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [31:0]        q_instr [DEPTH];
    logic [31:0]        q_pc    [DEPTH];
    logic [31:0]        addr_q;

    // The in-flight fetch reserves a queue slot, so a push can never find it full.
    assign outstanding = (state != IDLE);
    assign space       = ({1'b0, count} + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(DEPTH);

    always_ff @(posedge ms_risc32_mp_clk_in) begin
        if (ms_risc32_mp_rst_in) state <= IDLE;
        else                     state <= nstate;
    end

    always_comb begin
        nstate         = state;
        start          = 1'b0;
        mis_set        = 1'b0;
        pc_advance_out = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en_in && !flush_in) begin
                    if (pc_in[1:0] != 2'b00)
                        mis_set = 1'b1;
                    else if (space && !misaligned_out) begin
                        start  = 1'b1;
                        nstate = REQ;
                    end
                end
            end
            REQ: begin
                if (imem.imem_ack_in) begin
                    pc_advance_out = !flush_in;
                    nstate         = IDLE;
                end else if (flush_in) begin
                    nstate = DROP;
                end
            end
            DROP: begin
                // Memory still owes us a response to a flushed fetch; swallow it.
                if (imem.imem_ack_in) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    assign push = pc_advance_out;
    assign pop  = instr_valid_out & instr_ready_in;

    always_ff @(posedge ms_risc32_mp_clk_in) begin
        if (ms_risc32_mp_rst_in) begin
            addr_q         <= '0;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            misaligned_out <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            assert (!(push && count == CNT_W'(DEPTH)));
            if (start) addr_q <= pc_in;
            if (flush_in) begin
                count          <= '0;
                rd_ptr         <= '0;
                wr_ptr         <= '0;
                misaligned_out <= 1'b0;
            end else begin
                if (mis_set) misaligned_out <= 1'b1;
                if (push) begin
                    q_instr[wr_ptr] <= imem.imem_rdata_in;
                    q_pc[wr_ptr]    <= addr_q;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign imem.imem_req_out  = outstanding;
    assign imem.imem_addr_out = addr_q;
    assign instr_valid_out    = (count != '0);
    assign instr_out          = q_instr[rd_ptr];
    assign instr_pc_out       = q_pc[rd_ptr];

endmodule

// File: tb/tb_msrv32_instr_fetch_ctrl.sv
// Bench for msrv32_instr_fetch_ctrl: directed vector table, then random
// traffic against a queue-based reference model.
module tb_msrv32_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, fetch_en, flush, ready;
    logic [31:0] pc;
    logic        adv, vld, mis;
    logic [31:0] ins, ipc;
    int          n_vec = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;

    msrv32_instr_fetch_ctrl_if imem ();

    msrv32_instr_fetch_ctrl #(.DEPTH(2)) dut (
        .ms_risc32_mp_clk_in (clk),
        .ms_risc32_mp_rst_in (rst),
        .pc_in               (pc),
        .fetch_en_in         (fetch_en),
        .flush_in            (flush),
        .imem                (imem),
        .pc_advance_out      (adv),
        .instr_valid_out     (vld),
        .instr_out           (ins),
        .instr_pc_out        (ipc),
        .instr_ready_in      (ready),
        .misaligned_out      (mis)
    );

    typedef struct {
        bit          chk;
        bit          rst, en, fl;
        logic [31:0] pc;
        bit          ack;
        logic [31:0] rd;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          adv, vld;
        logic [31:0] ins, ipc;
        bit          mis, dchk;
    } vec_t;

    function automatic vec_t v(bit chk, bit r, bit en, bit fl, logic [31:0] p, bit ack,
                               logic [31:0] rd, bit rdy, bit req, logic [31:0] addr,
                               bit a, bit vl, logic [31:0] in, logic [31:0] ip,
                               bit m, bit dchk);
        vec_t t;
        t.chk = chk; t.rst = r; t.en = en; t.fl = fl; t.pc = p; t.ack = ack; t.rd = rd;
        t.rdy = rdy; t.req = req; t.addr = addr; t.adv = a; t.vld = vl; t.ins = in;
        t.ipc = ip; t.mis = m; t.dchk = dchk;
        return t;
    endfunction

    // Reference model: a queue of fetched words and at most one pending fetch.
    logic [31:0] mq_pc [$];
    logic [31:0] mq_in [$];
    bit          m_pend, m_drop, m_mis;
    logic [31:0] m_addr;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_all(bit e_req, logic [31:0] e_addr, bit e_adv, bit e_vld,
                           logic [31:0] e_ins, logic [31:0] e_ipc, bit e_mis, bit dchk);
        chk("imem_req", 32'(imem.imem_req_out), 32'(e_req));
        chk("imem_addr", imem.imem_addr_out, e_addr);
        chk("pc_advance", 32'(adv), 32'(e_adv));
        chk("instr_valid", 32'(vld), 32'(e_vld));
        chk("misaligned", 32'(mis), 32'(e_mis));
        if (dchk) begin
            chk("instr", ins, e_ins);
            chk("instr_pc", ipc, e_ipc);
        end
    endtask

    task automatic apply(bit r, bit en, bit fl, logic [31:0] p, bit ack, logic [31:0] rd, bit rdy);
        @(negedge clk);
        rst = r; fetch_en = en; flush = fl; pc = p; ready = rdy;
        imem.imem_ack_in = ack; imem.imem_rdata_in = rd;
        #1;
    endtask

    function automatic bit model_adv();
        return m_pend && !m_drop && imem.imem_ack_in && !flush;
    endfunction

    task automatic model_check();
        bit e_vld;
        e_vld = (mq_pc.size() != 0);
        cmp_all(m_pend, m_addr, model_adv(), e_vld,
                e_vld ? mq_in[0] : 32'h0, e_vld ? mq_pc[0] : 32'h0, m_mis, e_vld);
    endtask

    // Advance one clock and move the model by the rules for that edge.
    task automatic step();
        int sz0;
        @(posedge clk);
        cyc++;
        sz0 = mq_pc.size();
        if (rst) begin
            mq_pc.delete(); mq_in.delete();
            m_pend = 0; m_drop = 0; m_mis = 0; m_addr = 0;
        end else if (flush) begin
            mq_pc.delete(); mq_in.delete();
            m_mis = 0;
            if (m_pend) begin
                if (imem.imem_ack_in) begin m_pend = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else begin
            if (sz0 != 0 && ready) begin
                void'(mq_pc.pop_front()); void'(mq_in.pop_front());
            end
            if (m_pend) begin
                if (imem.imem_ack_in) begin
                    if (!m_drop) begin
                        mq_pc.push_back(m_addr); mq_in.push_back(imem.imem_rdata_in);
                    end
                    m_pend = 0; m_drop = 0;
                end
            end else if (fetch_en) begin
                if (pc[1:0] != 2'b00) m_mis = 1;
                else if (!m_mis && sz0 < 2) begin
                    m_pend = 1; m_drop = 0; m_addr = pc;
                end
            end
        end
    endtask

    vec_t        tab [$];
    logic [31:0] bpc;
    bit          r_rst, r_en, r_fl, r_ack, r_rdy, a;

    initial begin
        rst = 1; fetch_en = 0; flush = 0; pc = 0; ready = 0;
        imem.imem_ack_in = 0; imem.imem_rdata_in = 0;
        m_pend = 0; m_drop = 0; m_mis = 0; m_addr = 0;

        //          chk rst en fl pc       ack rdata        rdy  req addr     adv vld instr        ipc      mis dchk
        tab.push_back(v(0, 1, 1, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,   0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 1, 1, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,   0, 0, 32'h0,        32'h0,   0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h0,   0, 32'h0,        0,   0, 32'h0,   0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h0,   1, 32'h00500093, 0,   1, 32'h0,   1, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h4,   0, 32'h0,        0,   0, 32'h0,   0, 1, 32'h00500093, 32'h0,   0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h4,   1, 32'h00100113, 0,   1, 32'h4,   1, 1, 32'h00500093, 32'h0,   0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h8,   0, 32'h0,        0,   0, 32'h4,   0, 1, 32'h00500093, 32'h0,   0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h8,   0, 32'h0,        0,   0, 32'h4,   0, 1, 32'h00500093, 32'h0,   0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h8,   0, 32'h0,        1,   0, 32'h4,   0, 1, 32'h00500093, 32'h0,   0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h8,   0, 32'h0,        0,   0, 32'h4,   0, 1, 32'h00100113, 32'h4,   0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h8,   0, 32'h0,        1,   1, 32'h8,   0, 1, 32'h00100113, 32'h4,   0, 1));
        tab.push_back(v(1, 0, 1, 1, 32'h8,   0, 32'h0,        0,   1, 32'h8,   0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h8,   0, 32'h0,        0,   1, 32'h8,   0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h8,   1, 32'hDEADBEEF, 0,   1, 32'h8,   0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 0, 0, 32'h10,  0, 32'h0,        0,   0, 32'h8,   0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h10,  0, 32'h0,        0,   0, 32'h8,   0, 0, 32'h0,        32'h0,   0, 0));
        for (int i = 0; i < 3; i++)
            tab.push_back(v(1, 0, 1, 0, 32'h10, 0, 32'h0,     0,   1, 32'h10,  0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h10,  1, 32'h00208193, 0,   1, 32'h10,  1, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 0, 0, 32'h14,  0, 32'h0,        0,   0, 32'h10,  0, 1, 32'h00208193, 32'h10,  0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h102, 0, 32'h0,        1,   0, 32'h10,  0, 1, 32'h00208193, 32'h10,  0, 1));
        tab.push_back(v(1, 0, 1, 0, 32'h102, 0, 32'h0,        0,   0, 32'h10,  0, 0, 32'h0,        32'h0,   1, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h104, 0, 32'h0,        0,   0, 32'h10,  0, 0, 32'h0,        32'h0,   1, 0));
        tab.push_back(v(1, 0, 1, 1, 32'h104, 0, 32'h0,        0,   0, 32'h10,  0, 0, 32'h0,        32'h0,   1, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h104, 0, 32'h0,        0,   0, 32'h10,  0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 1, 32'h104, 1, 32'h11111111, 0,   1, 32'h104, 0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 0, 0, 32'h104, 0, 32'h0,        0,   0, 32'h104, 0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 0, 0, 32'h104, 1, 32'h22222222, 0,   0, 32'h104, 0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 0, 0, 32'h104, 0, 32'h0,        0,   0, 32'h104, 0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 1, 0, 32'h200, 0, 32'h0,        0,   0, 32'h104, 0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 1, 0, 0, 32'h200, 0, 32'h0,        0,   1, 32'h200, 0, 0, 32'h0,        32'h0,   0, 0));
        tab.push_back(v(1, 0, 0, 0, 32'h200, 1, 32'h33333333, 0,   0, 32'h0,   0, 0, 32'h0,        32'h0,   0, 1));

        foreach (tab[i]) begin
            apply(tab[i].rst, tab[i].en, tab[i].fl, tab[i].pc, tab[i].ack, tab[i].rd, tab[i].rdy);
            if (tab[i].chk)
                cmp_all(tab[i].req, tab[i].addr, tab[i].adv, tab[i].vld,
                        tab[i].ins, tab[i].ipc, tab[i].mis, tab[i].dchk);
            step();
        end

        // Random traffic; bpc behaves like the PC register feeding pc_in.
        bpc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_en  = ($urandom_range(0, 7) != 0);
            r_ack = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            r_rdy = $urandom_range(0, 1) != 0;
            apply(r_rst, r_en, r_fl, bpc, r_ack, $urandom, r_rdy);
            model_check();
            a = model_adv();
            step();
            if (r_rst)      bpc = 32'h0;
            else if (r_fl)  bpc = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            else if (a)     bpc = bpc + 32'h4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
